// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - shared op codes for the max priority queue and its front end
package pq_pkg;

  typedef logic [1:0] pq_op_t;

  localparam pq_op_t OP_NOP  = 2'b00;
  localparam pq_op_t OP_PUSH = 2'b01;
  localparam pq_op_t OP_POP  = 2'b10;
  localparam pq_op_t OP_TOP  = 2'b11;

endpackage

// File: rtl/pq_op_sequencer_if.sv
// rtl/pq_op_sequencer_if.sv - op port between the sequencer and the priority queue
interface pq_op_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  import pq_pkg::*;

  logic [DATA_WIDTH-1:0] pq_data_in;
  logic                  pq_valid_in;
  pq_op_t                pq_op;
  logic                  pq_ready_in;
  logic                  pq_ready_out;
  logic [DATA_WIDTH-1:0] pq_out;
  logic                  pq_valid_out;

  modport master (
    output pq_data_in, pq_valid_in, pq_op, pq_ready_in,
    input  pq_ready_out, pq_out, pq_valid_out
  );

  modport slave (
    input  pq_data_in, pq_valid_in, pq_op, pq_ready_in,
    output pq_ready_out, pq_out, pq_valid_out
  );

endinterface

// File: rtl/pq_push_fifo.sv
// rtl/pq_push_fifo.sv - push buffer with registered occupancy and registered head
module pq_push_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic                  wr;
  logic                  rd;

  assign full  = (count == CNT_WIDTH'(DEPTH));
  assign empty = (count == '0);
  assign wr    = wr_en & ~full;
  assign rd    = rd_en & ~empty;

  // Next head: a write into the slot that becomes the head bypasses the array
  always_comb begin
    rd_ptr_nxt = rd ? rd_ptr + PTR_W'(1) : rd_ptr;
    if (wr && (wr_ptr == rd_ptr_nxt)) begin
      head_nxt = wr_data;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // Pointers, occupancy and head register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count + CNT_WIDTH'(wr) - CNT_WIDTH'(rd);
      head   <= head_nxt;
    end
  end

  // Storage array; no reset needed since occupancy qualifies every entry
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/pq_op_sequencer.sv
// rtl/pq_op_sequencer.sv - serialises buffered pushes and pop requests onto the queue op port
module pq_op_sequencer
  import pq_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int PUSH_FIFO_DEPTH = 4,
  parameter int CNT_WIDTH       = $clog2(PUSH_FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic                  pop_req_valid,
  output logic                  pop_req_ready,
  output logic [DATA_WIDTH-1:0] pop_resp_data,
  output logic                  pop_resp_empty,
  output logic                  pop_resp_valid,
  input  logic                  pop_resp_ready,
  output logic                  push_drop,
  pq_op_sequencer_if.master     pq
);

  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CNT_WIDTH-1:0]  fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_rd;

  logic                  pop_pending;
  logic [CNT_WIDTH-1:0]  pushes_ahead;
  logic                  ahead_zero;
  logic                  pop_blocking;
  logic                  resp_free;
  logic                  push_in;
  logic                  pop_accept;
  logic                  pop_issue;
  logic                  empty_resp;
  logic                  push_issue;
  logic                  drop_head;
  logic [CNT_WIDTH-1:0]  occ_after;

  pq_push_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (PUSH_FIFO_DEPTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_push_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_in),
    .wr_data (push_data),
    .rd_en   (fifo_rd),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign push_ready    = ~fifo_full;
  assign pop_req_ready = ~pop_pending;
  assign push_in       = push_valid & push_ready;
  assign pop_accept    = pop_req_valid & pop_req_ready;
  assign resp_free     = ~pop_resp_valid | pop_resp_ready;
  assign ahead_zero    = (pushes_ahead == '0);
  // Once every push ahead of the pending pop has gone, later pushes must wait
  assign pop_blocking  = pop_pending & ahead_zero;

  assign pop_issue  = pop_blocking & resp_free & pq.pq_valid_out;
  assign empty_resp = pop_blocking & resp_free & ~pq.pq_valid_out;
  assign push_issue = ~fifo_empty & ~pop_blocking & pq.pq_ready_out;
  // A full queue cannot take the pushes ahead of a pop, so shed them to keep the pop moving
  assign drop_head  = ~fifo_empty & pop_pending & ~ahead_zero & ~pq.pq_ready_out;
  assign fifo_rd    = push_issue | drop_head;
  assign occ_after  = fifo_count + CNT_WIDTH'(push_in) - CNT_WIDTH'(fifo_rd);

  // Drive the queue op port from this cycle's issue decision
  always_comb begin
    pq.pq_op       = OP_NOP;
    pq.pq_valid_in = 1'b0;
    pq.pq_ready_in = 1'b0;
    pq.pq_data_in  = fifo_head;
    if (pop_issue) begin
      pq.pq_op       = OP_POP;
      pq.pq_ready_in = 1'b1;
    end else if (push_issue) begin
      pq.pq_op       = OP_PUSH;
      pq.pq_valid_in = 1'b1;
    end
  end

  // Track the pending pop and how many buffered pushes are ordered before it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_pending  <= 1'b0;
      pushes_ahead <= '0;
    end else begin
      if (pop_accept) begin
        pop_pending  <= 1'b1;
        pushes_ahead <= occ_after;
      end else begin
        if (pop_issue || empty_resp) begin
          pop_pending <= 1'b0;
        end
        if (fifo_rd && !ahead_zero) begin
          pushes_ahead <= pushes_ahead - CNT_WIDTH'(1);
        end
      end
    end
  end

  // Response register: load on a completed pop, otherwise drain on ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_resp_valid <= 1'b0;
      pop_resp_data  <= '0;
      pop_resp_empty <= 1'b0;
    end else if (pop_issue) begin
      pop_resp_valid <= 1'b1;
      pop_resp_data  <= pq.pq_out;
      pop_resp_empty <= 1'b0;
    end else if (empty_resp) begin
      pop_resp_valid <= 1'b1;
      pop_resp_data  <= '0;
      pop_resp_empty <= 1'b1;
    end else if (pop_resp_ready) begin
      pop_resp_valid <= 1'b0;
    end
  end

  // One-cycle pulse after a head push is discarded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_drop <= 1'b0;
    end else begin
      push_drop <= drop_head;
    end
  end

endmodule

// File: tb/tb_pq_op_sequencer.sv
// tb/tb_pq_op_sequencer.sv - directed bench for pq_op_sequencer with an 8-deep queue model
module tb_pq_op_sequencer;
  import pq_pkg::*;

  localparam int DW    = 8;
  localparam int QDEPTH = 8;

  typedef struct {
    int          cyc;
    logic [1:0]  op;
  } op_rec_t;

  typedef struct {
    int          cyc;
    logic        empty;
    logic [DW-1:0] data;
  } resp_rec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] push_data;
  logic          push_valid;
  logic          push_ready;
  logic          pop_req_valid;
  logic          pop_req_ready;
  logic [DW-1:0] pop_resp_data;
  logic          pop_resp_empty;
  logic          pop_resp_valid;
  logic          pop_resp_ready;
  logic          push_drop;

  pq_op_sequencer_if #(.DATA_WIDTH(DW)) pqi ();

  pq_op_sequencer #(
    .DATA_WIDTH      (DW),
    .PUSH_FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .push_data      (push_data),
    .push_valid     (push_valid),
    .push_ready     (push_ready),
    .pop_req_valid  (pop_req_valid),
    .pop_req_ready  (pop_req_ready),
    .pop_resp_data  (pop_resp_data),
    .pop_resp_empty (pop_resp_empty),
    .pop_resp_valid (pop_resp_valid),
    .pop_resp_ready (pop_resp_ready),
    .push_drop      (push_drop),
    .pq             (pqi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int drop_cnt = 0;
  op_rec_t   op_log[$];
  resp_rec_t resp_log[$];

  // Behavioural max priority queue
  logic [DW-1:0] qm [QDEPTH];
  int            qcnt = 0;
  logic [DW-1:0] q_max;
  int            q_mi;
  logic [1:0]    op_s = OP_NOP;
  logic [DW-1:0] din_s = '0;
  logic          vin_s = 1'b0;
  logic          rin_s = 1'b0;

  always_comb begin
    q_max = '0;
    q_mi  = 0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (i < qcnt && qm[i] >= q_max) begin
        q_max = qm[i];
        q_mi  = i;
      end
    end
  end

  assign pqi.pq_out       = q_max;
  assign pqi.pq_valid_out = (qcnt != 0);
  assign pqi.pq_ready_out = (qcnt < QDEPTH);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (op_s == OP_PUSH && vin_s && qcnt < QDEPTH) begin
      qm[qcnt] <= din_s;
      qcnt     <= qcnt + 1;
    end else if (op_s == OP_POP && rin_s && qcnt > 0) begin
      qm[q_mi] <= qm[qcnt-1];
      qcnt     <= qcnt - 1;
    end
  end

  always @(negedge clk) begin
    op_s  = pqi.pq_op;
    din_s = pqi.pq_data_in;
    vin_s = pqi.pq_valid_in;
    rin_s = pqi.pq_ready_in;
    if (pqi.pq_op != OP_NOP) op_log.push_back('{cyc, pqi.pq_op});
    if (pop_resp_valid && pop_resp_ready) resp_log.push_back('{cyc, pop_resp_empty, pop_resp_data});
    if (push_drop) drop_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    int k = 0;
    while (!push_ready && k < 50) begin tick(1); k++; end
    if (k >= 50) check("push_ready_timeout", 0, 1);
    push_data  = v;
    push_valid = 1'b1;
    tick(1);
    push_valid = 1'b0;
  endtask

  task automatic pop_req(output int acc);
    int k = 0;
    while (!pop_req_ready && k < 50) begin tick(1); k++; end
    if (k >= 50) check("pop_req_ready_timeout", 0, 1);
    pop_req_valid = 1'b1;
    tick(1);
    acc = cyc;
    pop_req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    int k = 0;
    while (resp_log.size() < n && k < 100) begin tick(1); k++; end
    check("resp_count", resp_log.size(), n);
  endtask

  function automatic int count_pops();
    int c = 0;
    foreach (op_log[i]) if (op_log[i].op == OP_POP) c++;
    return c;
  endfunction

  int a0, a1, a2, b0, b1, c0;

  initial begin
    reset          = 1'b0;
    push_data      = '0;
    push_valid     = 1'b0;
    pop_req_valid  = 1'b0;
    pop_resp_ready = 1'b1;
    #12;
    check("rst_push_ready", push_ready, 1);
    check("rst_pop_req_ready", pop_req_ready, 1);
    check("rst_resp_valid", pop_resp_valid, 0);
    check("rst_pq_op", pqi.pq_op, OP_NOP);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(2);

    // push 5, 9, 3 then three pops
    op_log.delete(); resp_log.delete();
    push(8'd5); push(8'd9); push(8'd3);
    pop_req(a0); pop_req(a1); pop_req(a2);
    wait_resp(3);
    if (resp_log.size() == 3) begin
      check("t1_resp0", resp_log[0].data, 9);
      check("t1_resp1", resp_log[1].data, 5);
      check("t1_resp2", resp_log[2].data, 3);
      check("t1_empty", {resp_log[0].empty, resp_log[1].empty, resp_log[2].empty}, 0);
      check("t1_resp0_cyc", resp_log[0].cyc, a0 + 1);
    end
    check("t1_ops", op_log.size(), 6);
    if (op_log.size() == 6) begin
      check("t1_op_seq", {op_log[0].op, op_log[1].op, op_log[2].op, op_log[3].op, op_log[4].op, op_log[5].op},
            {OP_PUSH, OP_PUSH, OP_PUSH, OP_POP, OP_POP, OP_POP});
      check("t1_pop0_cyc", op_log[3].cyc, a0);
      check("t1_pop1_cyc", op_log[4].cyc, a1);
      check("t1_pop2_cyc", op_log[5].cyc, a2);
    end
    tick(2);

    // push and pop request in the same cycle on an empty queue
    op_log.delete(); resp_log.delete();
    push_data = 8'd4; push_valid = 1'b1; pop_req_valid = 1'b1;
    tick(1);
    push_valid = 1'b0; pop_req_valid = 1'b0;
    wait_resp(1);
    if (resp_log.size() == 1) begin
      check("t2_data", resp_log[0].data, 4);
      check("t2_empty", resp_log[0].empty, 0);
    end
    if (op_log.size() == 2) check("t2_ops", {op_log[0].op, op_log[1].op}, {OP_PUSH, OP_POP});
    else check("t2_ops_n", op_log.size(), 2);
    tick(2);

    // pop on an empty queue
    op_log.delete(); resp_log.delete();
    pop_req(a0);
    wait_resp(1);
    if (resp_log.size() == 1) begin
      check("t3_data", resp_log[0].data, 0);
      check("t3_empty", resp_log[0].empty, 1);
      check("t3_cyc", resp_log[0].cyc, a0 + 1);
    end
    check("t3_no_ops", op_log.size(), 0);
    tick(2);

    // response backpressure holds the second pop
    push(8'd7); push(8'd2);
    tick(3);
    op_log.delete(); resp_log.delete();
    pop_resp_ready = 1'b0;
    pop_req(b0); pop_req(b1);
    tick(5);
    check("t4_one_pop", count_pops(), 1);
    check("t4_held_valid", pop_resp_valid, 1);
    check("t4_held_data", pop_resp_data, 7);
    check("t4_pending", pop_req_ready, 0);
    pop_resp_ready = 1'b1;
    wait_resp(2);
    if (resp_log.size() == 2) begin
      check("t4_resp0", resp_log[0].data, 7);
      check("t4_resp1", resp_log[1].data, 2);
    end
    check("t4_two_pops", count_pops(), 2);
    tick(2);

    // full queue: head push is dropped so the pop can proceed
    op_log.delete(); resp_log.delete(); drop_cnt = 0;
    for (int v = 1; v <= 8; v++) push(DW'(v));
    push(8'd20);
    tick(3);
    check("t5_no_drop_yet", drop_cnt, 0);
    check("t5_queue_full", pqi.pq_ready_out, 0);
    pop_req(a0);
    wait_resp(1);
    if (resp_log.size() == 1) check("t5_resp", resp_log[0].data, 8);
    tick(2);
    check("t5_drop_once", drop_cnt, 1);
    for (int i = 0; i < 7; i++) pop_req(a1);
    wait_resp(8);
    if (resp_log.size() == 8) begin
      for (int j = 1; j < 8; j++) check("t5_rest", {resp_log[j].empty, resp_log[j].data}, {1'b0, DW'(8 - j)});
    end
    check("t5_drop_total", drop_cnt, 1);
    tick(2);

    // reset with buffered pushes and a pending pop
    for (int v = 10; v <= 17; v++) push(DW'(v));
    push(8'd30); push(8'd31); push(8'd32);
    tick(3);
    check("t6_buffered", push_ready, 1);
    pop_req(c0);
    check("t6_pending", pop_req_ready, 0);
    #1;
    reset = 1'b0;
    #1;
    check("t6_push_ready", push_ready, 1);
    check("t6_pop_req_ready", pop_req_ready, 1);
    check("t6_resp", {pop_resp_valid, pop_resp_empty, pop_resp_data}, 0);
    check("t6_drop", push_drop, 0);
    check("t6_port", {pqi.pq_op, pqi.pq_valid_in, pqi.pq_ready_in}, 0);
    tick(2);
    reset = 1'b1;
    op_log.delete();
    tick(6);
    check("t6_no_ops", op_log.size(), 0);
    check("t6_push_ready_after", push_ready, 1);
    check("t6_no_resp", pop_resp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pq_op_sequencer.md
Name: pq_op_sequencer

Overview:
- Front-end controller that owns the single op port of the max priority queue (push/pop/top/nop op codes, combinational max output).
- Takes push traffic from one client and pop requests from another, buffers pushes, serialises both into one queue op per cycle in strict arrival order, and returns popped values through a registered response port.
- Sits directly upstream of the queue and also consumes its pq_out/valid_out.

Parameters:
- DATA_WIDTH, 8, width of each queued element.
- PUSH_FIFO_DEPTH, 4, entries in the push buffer; power of two, at least 2.
- CNT_WIDTH, $clog2(PUSH_FIFO_DEPTH)+1, occupancy/counter width.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- push_data  in  DATA_WIDTH  value to enqueue.
- push_valid  in  1  push request.
- push_ready  out  1  push FIFO not full (registered occupancy).
- pop_req_valid  in  1  pop request.
- pop_req_ready  out  1  high when no pop is pending.
- pop_resp_data  out  DATA_WIDTH  popped max value.
- pop_resp_empty  out  1  pop found the queue empty; pop_resp_data is 0.
- pop_resp_valid  out  1  response valid.
- pop_resp_ready  in  1  response consumed.
- push_drop  out  1  one-cycle pulse: head push discarded.
- pq_data_in  out  DATA_WIDTH  to queue data_in; equals FIFO head.
- pq_valid_in  out  1  to queue valid_in.
- pq_op  out  2  to queue op: 00 NOP, 01 PUSH, 10 POP; 11 is never driven.
- pq_ready_in  out  1  to queue ready_in.
- pq_ready_out  in  1  queue not full.
- pq_out  in  DATA_WIDTH  queue current max.
- pq_valid_out  in  1  queue non-empty.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; push_ready=1.
  - pop_pending=0; pop_req_ready=1.
  - pushes_ahead=0.
  - pop_resp_valid=0, pop_resp_data=0, pop_resp_empty=0.
  - push_drop=0; pq_op=NOP; pq_valid_in=0; pq_ready_in=0.
- Push acceptance: on push_valid & push_ready, write into FIFO tail.
- Pop acceptance: on pop_req_valid & pop_req_ready:
  - set pop_pending;
  - load pushes_ahead = FIFO occupancy after this cycle's write/issue, i.e. occ + push_in - push_issue.
  - A push accepted in the same cycle is ordered before the pop.
- resp_free = ~pop_resp_valid | pop_resp_ready.
- Issue decision, combinational, at most one per cycle:
  - pop_issue = pop_pending & pushes_ahead==0 & resp_free & pq_valid_out.
    - Drives pq_op=POP and pq_ready_in=1.
    - At the edge, pq_out is captured into pop_resp_data, pop_resp_empty=0, pop_resp_valid=1, and pop_pending clears.
  - empty_resp = pop_pending & pushes_ahead==0 & resp_free & ~pq_valid_out.
    - Drives pq_op=NOP.
    - At the edge, response is data=0 with pop_resp_empty=1; pop_pending clears.
  - push_issue = FIFO non-empty & ~(pop_pending & pushes_ahead==0) & pq_ready_out.
    - Drives pq_op=PUSH, pq_valid_in=1, pq_data_in=head.
    - At the edge: FIFO pops; pushes_ahead decrements if non-zero.
  - Drop case: FIFO non-empty & pop_pending & pushes_ahead>0 & ~pq_ready_out.
    - Head is discarded; push_drop pulses the next cycle; pushes_ahead decrements.
    - This prevents deadlock on a full queue.
  - Otherwise, with FIFO non-empty and queue full and no eligible pop, the head waits.
  - Otherwise pq_op=NOP.
- Response register:
  - Clears pop_resp_valid on pop_resp_ready when nothing new is loaded.
  - Load and drain in the same cycle is allowed.
- Latency:
  - Pop request at edge T with no pushes ahead and an empty response register → POP issued in cycle T+1 → pop_resp_valid from T+2.
  - Push to the queue occurs 1 cycle after FIFO acceptance at the earliest.
- Ordering: operations reach the queue in acceptance order. Pushes accepted after a pending pop wait until it issues.
- Reset mid-operation: all buffered pushes and the pending pop are lost; no queue op is driven while reset is asserted.

Decomposition:
- Shared package pq_pkg: OP_NOP/OP_PUSH/OP_POP/OP_TOP localparams (2-bit); reused by the queue.
- Sub-module pq_push_fifo: synchronous FIFO with registered occupancy, full/empty, and registered head output.
- Issue logic, counter, and response register stay in the top level.

Test Plan:
- Push 5, 9, 3 back-to-back, then pop ×3 with pop_resp_ready=1 → responses 9, 5, 3, pop_resp_empty=0; pq_op shows PUSH×3 then POP, each POP one cycle after pop_req acceptance.
- Push 4 and pop_req in the same cycle on an empty queue → PUSH issued first, response 4 (not empty).
- Pop_req on an empty queue with empty FIFO → response data=0, pop_resp_empty=1 two cycles later; pq_op stays NOP.
- Hold pop_resp_ready=0 after one response, then issue a second pop_req → no POP issued until the first response is consumed; then response is the next max.
- Fill an 8-deep queue with values 1..8, push 20, then pop_req → push_drop pulses once, pop returns 8, queue still holds 1..7.
- Assert reset low mid-stream with 3 pushes buffered and a pop pending → all outputs take reset values asynchronously; after release push_ready=1 and no ops are issued.
